// File: rtl/dram_line_adapter.sv
// Wishbone line slave: splits each LINE_W line cycle into BEATS narrow req/ready beats, reassembles reads.
// Latency: write ACK 5 cycles, read ACK 7 cycles (no stalls, 2-cycle return). Stalls hold the beat stable; ACK/RTY waits.
module dram_line_adapter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int BEAT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [LINE_W/8-1:0]   wb_sel,
  input  logic [ADDR_W-1:0]     wb_adr,
  input  logic [LINE_W-1:0]     wb_dat_m,
  output logic [LINE_W-1:0]     wb_dat_s,
  output logic                  wb_ack,
  output logic                  wb_rty,
  output logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [BEAT_W-1:0]     mem_wdata,
  output logic [BEAT_W/8-1:0]   mem_be,
  input  logic                  mem_rvalid,
  input  logic [BEAT_W-1:0]     mem_rdata,
  input  logic                  mem_err
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int BW    = $clog2(BEATS);
  localparam int LO    = $clog2(LINE_W / 8);
  localparam int BO    = $clog2(BEAT_W / 8);
  localparam int SW    = BEAT_W / 8;
  localparam logic [BW:0] LAST_BEAT = (BW + 1)'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t                  state, state_nxt;
  logic                    we_q, err_q;
  logic [LINE_W/8-1:0]     sel_q;
  logic [ADDR_W-1:LO]      adr_q;
  logic [LINE_W-1:0]       dat_q, line_q, dat_s_q;
  logic [BW:0]             beat, rbeat, rbeat_nxt;
  logic [BW-1:0]           beat_idx, rbeat_idx;
  logic                    start, issue, accept, rd_ret, last_acc, last_ret;
  logic                    unused_adr_bits;

  // Sub-line address bits select nothing: the whole line always moves.
  assign unused_adr_bits = ^wb_adr[LO-1:0];

  assign beat_idx  = beat[BW-1:0];
  assign rbeat_idx = rbeat[BW-1:0];
  assign start     = (state == S_IDLE) && wb_cyc && wb_stb;
  assign issue     = (state == S_ISSUE);
  assign accept    = issue && mem_ready;
  // Only returns for reads actually accepted by memory are counted.
  assign rd_ret    = mem_rvalid && !we_q && (rbeat < beat) &&
                     (state inside {S_ISSUE, S_WAIT, S_DRAIN});
  assign last_acc  = accept && (beat == LAST_BEAT);
  assign last_ret  = rd_ret && (rbeat == LAST_BEAT);
  assign rbeat_nxt = rbeat + {{BW{1'b0}}, rd_ret};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (!wb_cyc)       state_nxt = we_q ? S_IDLE : S_DRAIN;
        else if (last_acc) state_nxt = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (!wb_cyc)       state_nxt = S_DRAIN;
        else if (last_ret) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      S_DRAIN: if (rbeat_nxt == beat) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    int woff;
    woff      = int'(beat_idx) * BEAT_W;
    mem_req   = issue;
    mem_we    = issue && we_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (issue) begin
      mem_addr  = {adr_q, beat_idx, {BO{1'b0}}};
      mem_wdata = dat_q[woff +: BEAT_W];
      mem_be    = sel_q[int'(beat_idx) * SW +: SW];
    end
    wb_ack   = (state == S_RESP) && !err_q;
    wb_rty   = (state == S_RESP) && err_q;
    // The fresh line is presented alongside its ACK, then held.
    wb_dat_s = (wb_ack && !we_q) ? line_q : dat_s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      line_q  <= '0;
      dat_s_q <= '0;
      beat    <= '0;
      rbeat   <= '0;
    end else begin
      if (start) begin
        we_q  <= wb_we;
        sel_q <= wb_sel;
        adr_q <= wb_adr[ADDR_W-1:LO];
        dat_q <= wb_dat_m;
        beat  <= '0;
        rbeat <= '0;
        err_q <= 1'b0;
      end
      if (accept) begin
        beat <= beat + (BW + 1)'(1);
        if (we_q && mem_err) err_q <= 1'b1;
      end
      if (rd_ret) begin
        rbeat <= rbeat_nxt;
        line_q[int'(rbeat_idx) * BEAT_W +: BEAT_W] <= mem_rdata;
        if (mem_err) err_q <= 1'b1;
      end
      if (wb_ack && !we_q) dat_s_q <= line_q;
    end
  end
endmodule

// File: tb/tb_dram_line_adapter.sv
// Bench for dram_line_adapter: vector table, directed stall/abort/reset sequences, randomized traffic vs a line-level model.
module tb_dram_line_adapter;
  localparam int BEATS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, wb_cyc, wb_stb, wb_we, wb_ack, wb_rty;
  logic [15:0]  wb_sel;
  logic [31:0]  wb_adr;
  logic [127:0] wb_dat_m, wb_dat_s;
  logic         mem_req, mem_ready, mem_we, mem_rvalid, mem_err;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_be;

  dram_line_adapter #(.ADDR_W(32), .LINE_W(128), .BEAT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s),
    .wb_ack(wb_ack), .wb_rty(wb_rty), .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tcyc     = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: reads return base+beat_index two cycles after acceptance, in order.
  typedef struct { int due; logic [31:0] data; logic err; } ret_t;
  typedef struct { int t; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } beat_t;
  ret_t        pend[$];
  beat_t       beats[$];
  logic [31:0] rd_base    = 32'h0;
  int          err_beat   = -1;
  int          ready_mode = 0;
  int          stall_left = 0;

  initial begin : memsim
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
      if (pend.size() > 0 && pend[0].due <= tcyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend[0].data;
        mem_err    = pend[0].err;
        void'(pend.pop_front());
      end
      if (mem_req === 1'b1 && mem_we && int'(mem_addr[3:2]) == err_beat) mem_err = 1'b1;
    end
  end

  initial begin : rdy
    mem_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) mem_ready = ($urandom_range(0, 3) != 0);
      else if (ready_mode == 2 && mem_req === 1'b1 && mem_addr[3:2] == 2'd2 && stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else mem_ready = 1'b1;
    end
  end

  initial begin : mon
    logic        stall_prev;
    logic [67:0] prev;
    stall_prev = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && mem_req) chk("held_beat", {mem_addr, mem_wdata, mem_be}, prev);
        if (mem_req === 1'b1 && mem_ready) begin
          beats.push_back('{tcyc, mem_we, mem_addr, mem_wdata, mem_be});
          if (!mem_we)
            pend.push_back('{tcyc + 2, rd_base + 32'(mem_addr[3:2]), int'(mem_addr[3:2]) == err_beat});
        end
        stall_prev = (mem_req === 1'b1) && !mem_ready;
        prev = {mem_addr, mem_wdata, mem_be};
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] l;
    for (int i = 0; i < BEATS; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic do_xfer(input string tag, input logic we, input logic [31:0] adr,
                         input logic [15:0] sel, input logic [127:0] dat, input logic [31:0] base,
                         input int eb, input logic exp_rty, input int exp_lat,
                         input logic [127:0] exp_dat, input logic hold, output int t_ack);
    int t0;
    bit done;
    rd_base = base; err_beat = eb; beats.delete();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_m = dat;
    t0 = tcyc; done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(posedge clk); #1;
      if (wb_ack || wb_rty) done = 1'b1;
    end
    t_ack = tcyc;
    chk({tag, "_resp"}, {wb_ack, wb_rty}, {!exp_rty, exp_rty});
    chk({tag, "_dat_s"}, wb_dat_s, exp_dat);
    if (exp_lat > 0) chk({tag, "_latency"}, 128'(t_ack - t0), 128'(exp_lat));
    chk({tag, "_nbeats"}, 128'(beats.size()), 128'(BEATS));
    for (int i = 0; i < beats.size() && i < BEATS; i++) begin
      logic [31:0] ea;
      ea = (adr & ~32'hF) + 32'(4 * i);
      chk($sformatf("%s_beat%0d", tag, i),
          {beats[i].addr, beats[i].we, beats[i].be, we ? beats[i].wdata : 32'h0},
          {ea, we, sel[i*4 +: 4], we ? dat[i*32 +: 32] : 32'h0});
    end
    if (!hold) begin
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {wb_ack, wb_rty, wb_dat_s}, {2'b00, exp_dat});
    end
  endtask

  typedef struct {
    string tag; logic we; logic [31:0] adr; logic [15:0] sel; logic [127:0] dat;
    logic [31:0] base; int eb; logic exp_rty; int exp_lat; logic [127:0] exp_dat;
  } vec_t;

  initial begin : main
    vec_t         vt[5];
    logic [127:0] model_good;
    int           t1, t2, nreq, nresp;

    vt[0] = '{"rd_basic", 1'b0, 32'h100, 16'hFFFF, 128'h0, 32'hA0, -1, 1'b0, 7,
              128'h000000A3_000000A2_000000A1_000000A0};
    vt[1] = '{"wr_sel", 1'b1, 32'h200, 16'h00F0, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000,
              32'h0, -1, 1'b0, 5, 128'h000000A3_000000A2_000000A1_000000A0};
    vt[2] = '{"rd_err", 1'b0, 32'h340, 16'hFFFF, 128'h0, 32'h10, 2, 1'b1, 7,
              128'h000000A3_000000A2_000000A1_000000A0};
    vt[3] = '{"rd_nosel", 1'b0, 32'h7FF7, 16'h0000, 128'h0, 32'h5000, -1, 1'b0, 7,
              128'h00005003_00005002_00005001_00005000};
    vt[4] = '{"wr_err", 1'b1, 32'h1238, 16'hFFFF, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
              32'h0, 1, 1'b1, 5, 128'h00005003_00005002_00005001_00005000};

    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_sel = '0; wb_adr = '0; wb_dat_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_ack, wb_rty}, '0);
    chk("reset_dat_s", wb_dat_s, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++)
      do_xfer(vt[v].tag, vt[v].we, vt[v].adr, vt[v].sel, vt[v].dat, vt[v].base, vt[v].eb,
              vt[v].exp_rty, vt[v].exp_lat, vt[v].exp_dat, 1'b0, t1);
    model_good = line_of(32'h5000);

    // memory stalls the third beat for three cycles
    ready_mode = 2; stall_left = 3;
    do_xfer("wr_stall", 1'b1, 32'h400, 16'hFFFF, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000,
            32'h0, -1, 1'b0, 8, model_good, 1'b0, t1);
    ready_mode = 0;

    // abort a read after two beats have been accepted
    rd_base = 32'h77; err_beat = -1; beats.delete();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h500; wb_sel = 16'hFFFF;
    repeat (2) begin @(posedge clk); #1; end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    nreq = 0; nresp = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_req) nreq++;
      if (wb_ack || wb_rty) nresp++;
    end
    chk("abort_accepted", 128'(beats.size()), 128'd2);
    chk("abort_no_req", 128'(nreq), 128'd0);
    chk("abort_no_resp", 128'(nresp), 128'd0);
    model_good = line_of(32'h900);
    do_xfer("rd_after_abort", 1'b0, 32'h600, 16'hFFFF, 128'h0, 32'h900, -1, 1'b0, 7,
            model_good, 1'b0, t1);

    // reset while waiting for read returns
    rd_base = 32'h300; err_beat = -1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h700;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_out", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_ack, wb_rty}, '0);
    chk("rst_wait_dat_s", wb_dat_s, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_xfer("b2b_first", 1'b0, 32'h800, 16'hFFFF, 128'h0, 32'h40, -1, 1'b0, 7,
            line_of(32'h40), 1'b1, t1);
    do_xfer("b2b_second", 1'b0, 32'h900, 16'hFFFF, 128'h0, 32'h80, -1, 1'b0, 8,
            line_of(32'h80), 1'b0, t2);
    chk("b2b_turnaround", 128'(beats.size() > 0 ? beats[0].t - t1 : -1), 128'd2);
    model_good = line_of(32'h80);

    // randomized traffic with random memory backpressure
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic        we, erx;
      logic [31:0] adr, base;
      logic [15:0] sel;
      logic [127:0] dat;
      int          r, eb;
      we   = 1'($urandom_range(0, 1));
      adr  = $urandom;
      sel  = 16'($urandom);
      dat  = {$urandom, $urandom, $urandom, $urandom};
      base = $urandom;
      r    = $urandom_range(0, 11);
      eb   = (r < BEATS) ? r : -1;
      erx  = (eb >= 0);
      if (!we && !erx) model_good = line_of(base);
      do_xfer($sformatf("rnd%0d", n), we, adr, sel, dat, base, eb, erx, 0, model_good, 1'b0, t1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
